// File: rtl/bin2ex3_pkg.sv
// Shared types and constants for the sequential binary-to-BCD/Excess-3 converter.
package bin2ex3_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic       MODE_BCD = 1'b0;
   localparam logic       MODE_EX3 = 1'b1;
   localparam logic [3:0] EX3_BIAS = 4'd3;

   // Map one BCD digit to the output code selected by mode.
   function automatic logic [3:0] encode_digit(input logic [3:0] bcd, input logic mode);
      return (mode == MODE_EX3) ? bcd + EX3_BIAS : bcd;
   endfunction

endpackage

// File: rtl/bin2ex3_seq_dd_digit_adj.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module dd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adj_c
);

   always_comb begin
      adj_c = (digit >= 4'd5) ? digit + 4'd3 : digit;
   end

endmodule

// File: rtl/bin2ex3_seq.sv
// Iterative double-dabble converter, one input bit per clock, BCD or Excess-3 output.
module bin2ex3_seq
   import bin2ex3_pkg::*;
#(
   parameter int unsigned W      = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          bin_in,
   input  logic                  mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   dec_out,
   output logic                  ovf
);

   localparam int unsigned DW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(W + 1);

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    bin_sr;
   logic [DW-1:0]   acc;
   logic [DW-1:0]   acc_adj_c;
   logic [DW-1:0]   acc_sh_c;
   logic [DW-1:0]   dec_nxt_c;
   logic            mode_q;
   logic [CW-1:0]   cnt;
   logic            load_c;
   logic            shift_c;
   logic            last_c;
   logic            release_c;

   // Per-digit correction and output encoding of the post-shift accumulator.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      dd_digit_adj u_adj (
         .digit (acc[4*g +: 4]),
         .adj_c (acc_adj_c[4*g +: 4])
      );
      assign dec_nxt_c[4*g +: 4] = encode_digit(acc_sh_c[4*g +: 4], mode_q);
   end

   // The top accumulator bit falls off here; it is a carry past 10^DIGITS.
   assign acc_sh_c = {acc_adj_c[DW-2:0], bin_sr[W-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_c)    state_nxt = SHIFT;
         SHIFT:   if (last_c)    state_nxt = DONE;
         DONE:    if (release_c) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_c    = 1'b0;
      shift_c   = 1'b0;
      last_c    = 1'b0;
      release_c = 1'b0;
      case (state)
         IDLE:    load_c    = in_valid && in_ready;
         SHIFT: begin
            shift_c = 1'b1;
            last_c  = (cnt == CW'(W - 1));
         end
         DONE:    release_c = out_ready;
         default: ;
      endcase
   end

   // Datapath and registered handshake outputs follow the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         dec_out   <= '0;
         ovf       <= 1'b0;
         bin_sr    <= '0;
         acc       <= '0;
         mode_q    <= MODE_BCD;
         cnt       <= '0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (load_c) begin
            bin_sr <= bin_in;
            mode_q <= mode;
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
         end
         if (shift_c) begin
            bin_sr <= {bin_sr[W-2:0], 1'b0};
            acc    <= acc_sh_c;
            ovf    <= ovf | acc_adj_c[DW-1];
            cnt    <= cnt + CW'(1);
         end
         if (last_c) begin
            dec_out <= dec_nxt_c;
         end
      end
   end

endmodule

// File: tb/tb_bin2ex3_seq.sv
// Directed and exhaustive checks of bin2ex3_seq at DIGITS=3 and DIGITS=2 in lockstep.
module tb_bin2ex3_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  bin_in = '0;
   logic        mode = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, ovf;
   logic [11:0] dec3;
   logic        in_ready2, out_valid2, ovf2;
   logic [7:0]  dec2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bin2ex3_seq #(.W(8), .DIGITS(3)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .bin_in(bin_in), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .dec_out(dec3), .ovf(ovf)
   );

   bin2ex3_seq #(.W(8), .DIGITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .bin_in(bin_in), .mode(mode), .out_valid(out_valid2),
      .out_ready(out_ready), .dec_out(dec2), .ovf(ovf2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ref_dec(input int v, input int nd, input logic m);
      logic [11:0] r = '0;
      int x = v;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(x % 10) + (m ? 4'd3 : 4'd0);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ex3_ok(input logic [11:0] d, input int nd);
      logic ok = 1'b1;
      for (int i = 0; i < nd; i++)
         if (d[4*i +: 4] < 4'd3 || d[4*i +: 4] > 4'd12) ok = 1'b0;
      return ok;
   endfunction

   // One conversion, entered and left on a falling edge; hold = cycles of backpressure.
   task automatic xfer(input logic [7:0] b, input logic m,
                       input logic [11:0] e3, input logic o3,
                       input logic [7:0] e2, input logic o2, input int hold);
      int cyc;
      logic [11:0] snap;
      chk("rdy_idle", in_ready, 1'b1);
      bin_in   = b;
      mode     = m;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      bin_in   = ~b;
      mode     = ~m;
      chk("rdy_busy", in_ready, 1'b0);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, 8);
      chk("vld2", out_valid2, out_valid);
      snap = dec3;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         bin_in   = 8'h5A;
         @(negedge clk);
         chk("hold_dec", dec3, snap);
         chk("hold_vld", out_valid, 1'b1);
         chk("hold_rdy", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      chk("dec3", dec3, e3);
      chk("ovf3", ovf, o3);
      chk("dec2", dec2, e2);
      chk("ovf2", ovf2, o2);
      if (m) begin
         chk("ex3_rng3", ex3_ok(dec3, 3), 1'b1);
         chk("ex3_rng2", ex3_ok({4'h0, dec2}, 2), 1'b1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("rel_vld", out_valid, 1'b0);
      chk("rel_rdy", in_ready, 1'b1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_rdy", in_ready, 1'b1);
      chk("rst_vld", out_valid, 1'b0);
      chk("rst_dec", dec3, 12'h000);
      chk("rst_ovf", ovf, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors; first one exercises backpressure.
      xfer(8'd255, 1'b1, 12'h588, 1'b0, 8'h88, 1'b1, 5);
      xfer(8'd0,   1'b1, 12'h333, 1'b0, 8'h33, 1'b0, 0);
      xfer(8'd99,  1'b0, 12'h099, 1'b0, 8'h99, 1'b0, 0);
      xfer(8'd200, 1'b1, 12'h533, 1'b0, 8'h33, 1'b1, 0);
      xfer(8'd45,  1'b1, 12'h378, 1'b0, 8'h78, 1'b0, 0);
      xfer(8'd100, 1'b0, 12'h100, 1'b0, 8'h00, 1'b1, 2);
      xfer(8'd9,   1'b1, 12'h33C, 1'b0, 8'h3C, 1'b0, 0);

      // Abort mid-SHIFT.
      bin_in = 8'd200; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_rdy", in_ready, 1'b1);
      chk("abort_vld", out_valid, 1'b0);
      chk("abort_ovf", ovf, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xfer(8'd137, 1'b1, 12'h46A, 1'b0, 8'h6A, 1'b1, 0);

      // Abort while DONE waits for the consumer.
      bin_in = 8'd77; mode = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("done_vld", out_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("abortd_vld", out_valid, 1'b0);
      chk("abortd_rdy", in_ready, 1'b1);
      chk("abortd_dec", dec3, 12'h000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Every input, both codes, back to back.
      for (int m = 0; m < 2; m++)
         for (int v = 0; v < 256; v++)
            xfer(8'(v), 1'(m), ref_dec(v, 3, 1'(m)), 1'b0,
                 8'(ref_dec(v, 2, 1'(m))), (v > 99), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
